// File: rtl/io_map_pkg.sv
// Shared CPU memory map: device addresses, timer register offsets and TCTL bit positions.
package io_map_pkg;

  localparam logic [31:0] ADDRHEX  = 32'hFFFFF000;
  localparam logic [31:0] ADDRLEDR = 32'hFFFFF020;
  localparam logic [31:0] ADDRKEY  = 32'hFFFFF080;
  localparam logic [31:0] ADDRSW   = 32'hFFFFF090;
  localparam logic [31:0] ADDRTCNT = 32'hFFFFF100;
  localparam logic [31:0] ADDRTLIM = 32'hFFFFF104;
  localparam logic [31:0] ADDRTCTL = 32'hFFFFF108;

  localparam int unsigned OFFTCNT = 0;
  localparam int unsigned OFFTLIM = 4;
  localparam int unsigned OFFTCTL = 8;

  localparam int unsigned TCTL_READY = 0;
  localparam int unsigned TCTL_OVR   = 2;
  localparam int unsigned TCTL_IE    = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: pulses tick for one cycle every TICKDIV cycles; clr restarts the count.
module tick_prescaler #(
  parameter int unsigned TICKDIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICKDIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped interval timer: TCNT/TLIM/TCTL registers with ready/overrun flags and interrupt.
module io_timer
  import io_map_pkg::*;
#(
  parameter int unsigned     DBITS   = 32,
  parameter logic [DBITS-1:0] BASE   = DBITS'(ADDRTCNT),
  parameter int unsigned     TICKDIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  output logic             sel,
  output logic [DBITS-1:0] rdata,
  output logic             intr
);

  localparam logic [DBITS-1:0] AddrTcnt = BASE + DBITS'(OFFTCNT);
  localparam logic [DBITS-1:0] AddrTlim = BASE + DBITS'(OFFTLIM);
  localparam logic [DBITS-1:0] AddrTctl = BASE + DBITS'(OFFTCTL);

  logic [DBITS-1:0] tcnt_q, tcnt_d;
  logic [DBITS-1:0] tlim_q, tlim_d;
  logic             ready_q, ready_d;
  logic             ovr_q, ovr_d;
  logic             ie_q, ie_d;

  logic sel_tcnt, sel_tlim, sel_tctl;
  logic wr_tcnt, wr_tlim, wr_tctl;
  logic tick, at_limit, limit_evt;

  // BASE is word aligned, so misaligned addresses never match.
  assign sel_tcnt = (addr == AddrTcnt);
  assign sel_tlim = (addr == AddrTlim);
  assign sel_tctl = (addr == AddrTctl);
  assign sel      = sel_tcnt | sel_tlim | sel_tctl;

  assign wr_tcnt = we & sel_tcnt;
  assign wr_tlim = we & sel_tlim;
  assign wr_tctl = we & sel_tctl;

  tick_prescaler #(
    .TICKDIV(TICKDIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (wr_tcnt | wr_tlim),
    .tick (tick)
  );

  assign at_limit  = (tlim_q != '0) && (tcnt_q == tlim_q - DBITS'(1));
  assign limit_evt = tick & at_limit & ~wr_tcnt & ~wr_tlim;

  always_comb begin
    tcnt_d  = tcnt_q;
    tlim_d  = tlim_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ie_d    = ie_q;

    if (wr_tcnt) begin
      tcnt_d = wdata;
    end else if (wr_tlim) begin
      tlim_d = wdata;
      tcnt_d = '0;
    end else if (tick) begin
      tcnt_d = at_limit ? '0 : tcnt_q + DBITS'(1);
    end

    if (wr_tctl) begin
      if (!wdata[TCTL_READY]) ready_d = 1'b0;
      if (!wdata[TCTL_OVR])   ovr_d   = 1'b0;
      ie_d = wdata[TCTL_IE];
    end

    // Limit event overrides a same-cycle clear; overrun uses ready before the write.
    if (limit_evt) begin
      ready_d = 1'b1;
      if (ready_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q  <= '0;
      tlim_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tlim_q  <= tlim_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_tcnt) begin
      rdata = tcnt_q;
    end else if (sel_tlim) begin
      rdata = tlim_q;
    end else if (sel_tctl) begin
      rdata[TCTL_READY] = ready_q;
      rdata[TCTL_OVR]   = ovr_q;
      rdata[TCTL_IE]    = ie_q;
    end
  end

  assign intr = ready_q & ie_q;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: directed scenarios plus randomized bus traffic vs. a model.
module tb_io_timer;

  localparam int unsigned TickDiv = 4;
  localparam logic [31:0] ATcnt = 32'hFFFFF100;
  localparam logic [31:0] ATlim = 32'hFFFFF104;
  localparam logic [31:0] ATctl = 32'hFFFFF108;

  logic        clk, reset, we, sel, intr;
  logic [31:0] addr, wdata, rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state: count, limit, flags and cycles elapsed within the current tick.
  logic [31:0] m_cnt, m_lim;
  logic        m_ready, m_ovr, m_ie;
  int unsigned m_phase;

  io_timer #(
    .DBITS  (32),
    .BASE   (ATcnt),
    .TICKDIV(TickDiv)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .we   (we),
    .sel  (sel),
    .rdata(rdata),
    .intr (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_lim = 0; m_ready = 0; m_ovr = 0; m_ie = 0; m_phase = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == ATcnt) return m_cnt;
    if (a == ATlim) return m_lim;
    if (a == ATctl) return {27'd0, m_ie, 1'b0, m_ovr, 1'b0, m_ready};
    return 32'd0;
  endfunction

  function automatic logic model_sel(input logic [31:0] a);
    return (a == ATcnt) || (a == ATlim) || (a == ATctl);
  endfunction

  // One clock edge of the timer as described by its register rules.
  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit tick_now, wcnt, wlim, wctl, evt;
    logic ready_before;
    tick_now = (m_phase == TickDiv - 1);
    wcnt = w && (a == ATcnt);
    wlim = w && (a == ATlim);
    wctl = w && (a == ATctl);
    ready_before = m_ready;
    evt = 0;
    if (wcnt || wlim) m_phase = 0;
    else m_phase = (m_phase + 1) % TickDiv;
    if (wcnt) m_cnt = d;
    else if (wlim) begin
      m_lim = d; m_cnt = 0;
    end else if (tick_now) begin
      if (m_lim != 0 && m_cnt + 1 == m_lim) begin
        m_cnt = 0; evt = 1;
      end else m_cnt = m_cnt + 1;
    end
    if (wctl) begin
      if (d[0] == 0) m_ready = 0;
      if (d[2] == 0) m_ovr = 0;
      m_ie = d[4];
    end
    if (evt) begin
      if (ready_before) m_ovr = 1;
      m_ready = 1;
    end
  endtask

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(w, a, d);
    #1;
    we = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] regs [3];
    regs = '{ATcnt, ATlim, ATctl};
    reset = 1; we = 0; addr = 0; wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      addr = regs[i]; #1;
      checks++;
      if (rdata !== 32'd0 || sel !== 1'b1 || intr !== 1'b0) begin
        errors++;
        $display("FAIL reset_read[%0d]: rdata=%h sel=%b intr=%b, want 0/1/0", i, rdata, sel, intr);
      end
    end
    addr = 32'hFFFFF10C; #1;
    checks++;
    if (sel !== 1'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_unmapped: sel=%b rdata=%h, want 0/0", sel, rdata);
    end
    addr = 32'hFFFFF101; #1;
    checks++;
    if (sel !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_sel: sel=%b, want 0", sel);
    end
    @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic test_limit();
    step(1, ATlim, 32'd3);
    for (int i = 0; i < 12; i++) begin
      step(0, 32'd0, 32'd0);
      addr = ATcnt; #1;
      checks++;
      if (rdata !== model_rd(ATcnt)) begin
        errors++;
        $display("FAIL limit_tcnt[%0d]: got %h, want %h", i, rdata, model_rd(ATcnt));
      end
    end
    addr = ATctl; #1;
    checks++;
    if (rdata !== 32'h1) begin
      errors++;
      $display("FAIL limit_ready: TCTL=%h, want 00000001", rdata);
    end
    idle(12);
    addr = ATctl; #1;
    checks++;
    if (rdata !== 32'h5) begin
      errors++;
      $display("FAIL overrun: TCTL=%h, want 00000005", rdata);
    end
    step(1, ATctl, 32'h0);
    addr = ATctl; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL tctl_clear: TCTL=%h, want 00000000", rdata);
    end
  endtask

  task automatic test_intr();
    bit seen = 0;
    step(1, ATctl, 32'h10);
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 32'd0, 32'd0);
      seen = (intr === 1'b1);
    end
    addr = ATctl; #1;
    checks++;
    if (!seen || rdata !== 32'h11) begin
      errors++;
      $display("FAIL intr_raise: intr=%b TCTL=%h, want 1/00000011", intr, rdata);
    end
    step(1, ATctl, 32'h10);
    addr = ATctl; #1;
    checks++;
    if (intr !== 1'b0 || rdata !== 32'h10) begin
      errors++;
      $display("FAIL intr_ack: intr=%b TCTL=%h, want 0/00000010", intr, rdata);
    end
  endtask

  task automatic test_freerun();
    step(1, ATlim, 32'd0);
    step(1, ATcnt, 32'hFFFFFFFF);
    idle(4);
    addr = ATcnt; #1;
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL freerun_wrap: TCNT=%h, want 00000000", rdata);
    end
    addr = ATctl; #1;
    checks++;
    if (rdata[0] !== 1'b0) begin
      errors++;
      $display("FAIL freerun_ready: ready=%b, want 0", rdata[0]);
    end
    idle(3);
    step(1, ATcnt, 32'h1234);
    addr = ATcnt; #1;
    checks++;
    if (rdata !== 32'h1234) begin
      errors++;
      $display("FAIL write_on_tick: TCNT=%h, want 00001234", rdata);
    end
  endtask

  task automatic test_clear_on_tick();
    step(1, ATlim, 32'd2);
    step(1, ATctl, 32'h0);
    idle(6);
    addr = ATcnt; #1;
    checks++;
    if (rdata !== 32'd1) begin
      errors++;
      $display("FAIL pre_clear_tcnt: TCNT=%h, want 00000001", rdata);
    end
    step(1, ATctl, 32'h0);
    addr = ATctl; #1;
    checks++;
    if (rdata !== 32'h1) begin
      errors++;
      $display("FAIL clear_on_tick: TCTL=%h, want 00000001", rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] regs [3];
    regs = '{ATcnt, ATlim, ATctl};
    step(1, ATlim, 32'd5);
    step(1, ATctl, 32'h10);
    for (int i = 0; i < 20 && m_cnt != 2; i++) step(0, 32'd0, 32'd0);
    addr = ATcnt; #1;
    checks++;
    if (rdata !== 32'd2) begin
      errors++;
      $display("FAIL mid_tcnt: TCNT=%h, want 00000002", rdata);
    end
    reset = 1; #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      addr = regs[i]; #1;
      checks++;
      if (rdata !== 32'd0 || intr !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d]: rdata=%h intr=%b, want 0/0", i, rdata, intr);
      end
    end
    @(negedge clk);
    reset = 0;
    #1;
    idle(4);
    addr = ATcnt; #1;
    checks++;
    if (rdata !== 32'd1) begin
      errors++;
      $display("FAIL resume: TCNT=%h, want 00000001", rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       step(1, ATcnt, 32'($urandom_range(0, 7)));
        1:       step(1, ATlim, 32'($urandom_range(0, 4)));
        2, 3:    step(1, ATctl, $urandom);
        4:       step(1, $urandom, $urandom);
        default: step(0, 32'd0, 32'd0);
      endcase
      case ($urandom_range(0, 3))
        0:       a = ATcnt;
        1:       a = ATlim;
        2:       a = ATctl;
        default: a = ATcnt + 32'($urandom_range(1, 15));
      endcase
      addr = a; #1;
      d = model_rd(a);
      checks++;
      if (rdata !== d || sel !== model_sel(a) || intr !== (m_ready & m_ie)) begin
        errors++;
        $display("FAIL random[%0d] addr=%h: rdata=%h sel=%b intr=%b, want %h/%b/%b",
                 i, a, rdata, sel, intr, d, model_sel(a), m_ready & m_ie);
      end
    end
  endtask

  initial begin
    test_reset();
    test_limit();
    test_intr();
    test_freerun();
    test_clear_on_tick();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped interval timer on the CPU data bus, next to the HEX/LEDR/KEY/SW devices.
- Driven by memaddr_M, wrmem_M and wmemval_M; returns read data that is muxed into memout_M.
- Three registers: TCNT at BASE, TLIM at BASE+4, TCTL at BASE+8. Counts prescaled ticks.
- Raises a ready flag and an optional interrupt when the count reaches its limit.

Parameters:
- DBITS, 32, data/address bus width.
- BASE, 32'hFFFFF100, address of TCNT; TLIM at BASE+4, TCTL at BASE+8.
- TICKDIV, 50000, clk cycles per timer tick; must be >= 1 (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  asynchronous, active-high; clock is clk.
- addr  in  DBITS  bus address (memaddr_M).
- wdata  in  DBITS  bus write data (wmemval_M).
- we  in  1  bus write strobe (wrmem_M).
- sel  out  1  addr matches one of the three registers (combinational).
- rdata  out  DBITS  read data for addr (combinational); 0 when sel=0.
- intr  out  1  interrupt request, equal to TCTL.ready & TCTL.ie.

Behaviour:
- Reset (async): TCNT=0, TLIM=0, TCTL=0, prescaler=0; so sel depends only on addr, rdata=0 except register reads of 0, intr=0.
- Prescaler counts 0..TICKDIV-1. tick=1 for exactly one cycle when prescaler==TICKDIV-1, then prescaler wraps to 0.
- Any write to TCNT or TLIM clears the prescaler to 0.
- On tick with no conflicting write:
  - If TLIM!=0 and TCNT==TLIM-1: TCNT<=0. If ready was 0, ready<=1; else overrun<=1.
  - Otherwise TCNT<=TCNT+1, wrapping modulo 2^DBITS.
- TLIM==0: TCNT free-runs and never sets ready or overrun.
- TCNT write: TCNT<=wdata. Any same-cycle tick increment or limit check is discarded.
- TLIM write: TLIM<=wdata and TCNT<=0. Any same-cycle tick is discarded.
- TCTL layout:
  - bit0 ready: write 0 clears, write 1 leaves unchanged.
  - bit2 overrun: write 0 clears, write 1 leaves unchanged.
  - bit4 ie: read/write.
  - All other bits read 0 and ignore writes.
- TCTL write in the same cycle as a limit event: the set wins over the clear, so no event is lost. Overrun is judged from ready's value before the write.
- Latency:
  - Register writes take effect at the next clk edge.
  - Reads are same-cycle combinational, matching the single-cycle memout_M path.
  - intr follows TCTL with no extra delay.
- Writes with we=1 to non-matching addresses have no effect. Misaligned addresses (addr[1:0]!=0) do not match.
- Reset asserted mid-count returns every register to 0 immediately. Counting resumes from 0 after deassertion.

Decomposition:
- Shared package io_map_pkg holds:
  - Device addresses (ADDRTCNT/TLIM/TCTL, ADDRHEX, ADDRLEDR, ADDRKEY, ADDRSW).
  - Register offsets 0/4/8.
  - TCTL bit indices READY=0, OVR=2, IE=4.
- One sub-module, tick_prescaler (params TICKDIV; ports clk, reset, clr, tick), owns the divider counter.
- Address decode, the register file and the read mux live in io_timer.

Test Plan (TICKDIV=4, BASE=32'hFFFFF100):
- Reset, then read each of the three addresses -> rdata=0, sel=1, intr=0. Read 32'hFFFFF10C -> sel=0, rdata=0.
- Write TLIM=3, then poll for 12 cycles -> TCNT reads 0,1,2,0 on successive ticks. TCTL reads 32'h1 after the wrapping tick; overrun=0.
- Leave ready set and wait 12 more cycles -> TCTL reads 32'h5. Write TCTL=32'h0 -> TCTL reads 0.
- Write TCTL=32'h10, then let a limit event occur -> intr=1, TCTL=32'h11. Write TCTL=32'h10 -> intr=0, TCTL=32'h10.
- TLIM=0, write TCNT=32'hFFFFFFFF -> after one tick TCNT=0, TCTL ready stays 0. Issue a TCNT write exactly on a tick cycle -> the written value is held, with no increment.
- Clear TCTL on the same cycle as a limit tick -> ready reads 1.
- Assert reset mid-count with TCNT=2 -> all registers read 0 immediately and intr=0.
